// File: rtl/wide_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : wide_add_sequencer
// Streams multi-word operands LSW-first through an external 16-bit adder slice
// Revision : 1.0
// ============================================================================
module wide_add_sequencer #(
    parameter int MAX_WORDS = 8,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    input  logic             in_sub,
    input  logic             in_last,
    output logic [15:0]      ADD_X,
    output logic [15:0]      ADD_Y,
    output logic             ADD_CIN,
    input  logic [15:0]      ADD_SUM,
    input  logic             ADD_COUT,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_sum,
    output logic             out_last,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_err,
    output logic [CNT_W-1:0] out_idx
);

    localparam logic [0:0]       c_idle    = 1'b0;
    localparam logic [0:0]       c_busy    = 1'b1;
    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(MAX_WORDS - 1);

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic             r_carry;
    logic             r_sub;
    logic [CNT_W-1:0] r_cnt;
    logic             w_accept;
    logic             w_sub_eff;
    logic             w_at_max;
    logic             w_last_eff;

    assign w_accept   = in_valid & in_ready;
    assign w_at_max   = (r_cnt == c_cnt_max);
    assign w_last_eff = in_last | w_at_max;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: any last word (explicit or forced) closes the operation
    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            w_state_nxt = w_last_eff ? c_idle : c_busy;
        end
    end

    // Output logic: adder drive and upstream ready
    always_comb begin
        in_ready  = !out_valid | out_ready;
        w_sub_eff = (r_state == c_idle) ? in_sub : r_sub;
        ADD_X     = in_a;
        ADD_Y     = in_b ^ {16{w_sub_eff}};
        ADD_CIN   = (r_state == c_idle) ? w_sub_eff : r_carry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_last  <= 1'b0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
            out_err   <= 1'b0;
            out_idx   <= '0;
            r_carry   <= 1'b0;
            r_sub     <= 1'b0;
            r_cnt     <= '0;
        end else if (w_accept) begin
            out_valid <= 1'b1;
            out_sum   <= ADD_SUM;
            out_idx   <= r_cnt;
            out_last  <= w_last_eff;
            out_err   <= w_at_max & !in_last;
            out_cout  <= w_last_eff & ADD_COUT;
            // Signed overflow: operands agree in sign, result disagrees
            out_ovf   <= w_last_eff & (in_a[15] == ADD_Y[15]) & (ADD_SUM[15] != in_a[15]);
            r_carry   <= ADD_COUT;
            r_sub     <= w_sub_eff;
            r_cnt     <= w_last_eff ? '0 : r_cnt + 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wide_add_sequencer.sv
`default_nettype none
// Testbench for wide_add_sequencer: random multi-word operations checked
// against whole-operand arithmetic through an expected-result queue.
module tb_wide_add_sequencer;

    localparam int MAXW = 8;
    localparam int CW   = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [15:0]   in_a = '0;
    logic [15:0]   in_b = '0;
    logic          in_sub = 1'b0;
    logic          in_last = 1'b0;
    logic [15:0]   ADD_X, ADD_Y, ADD_SUM;
    logic          ADD_CIN, ADD_COUT;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [15:0]   out_sum;
    logic          out_last, out_cout, out_ovf, out_err;
    logic [CW-1:0] out_idx;

    int bp_mode  = 0;
    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0]   sum;
        logic          last;
        logic          cout;
        logic          ovf;
        logic          err;
        logic [CW-1:0] idx;
    } exp_t;

    exp_t q[$];

    wide_add_sequencer #(.MAX_WORDS(MAXW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_last(in_last),
        .ADD_X(ADD_X), .ADD_Y(ADD_Y), .ADD_CIN(ADD_CIN),
        .ADD_SUM(ADD_SUM), .ADD_COUT(ADD_COUT),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_last(out_last), .out_cout(out_cout),
        .out_ovf(out_ovf), .out_err(out_err), .out_idx(out_idx)
    );

    // Behavioural stand-in for the 16-bit adder slice
    assign {ADD_COUT, ADD_SUM} = {1'b0, ADD_X} + {1'b0, ADD_Y} + 17'(ADD_CIN);

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Downstream ready: 0 = always ready, 1 = random, 2 = stalled
    initial begin : ready_gen
        forever begin
            @(negedge clk);
            case (bp_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 2) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    initial begin : monitor
        exp_t        e;
        logic        held = 1'b0;
        logic [15:0] h_sum;
        logic [CW-1:0] h_idx;
        logic        h_last;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    chk("hold_valid", 32'(out_valid), 32'd1);
                    chk("hold_sum", 32'(out_sum), 32'(h_sum));
                    chk("hold_idx", 32'(out_idx), 32'(h_idx));
                    chk("hold_last", 32'(out_last), 32'(h_last));
                end
                held   = out_valid && !out_ready;
                h_sum  = out_sum;
                h_idx  = out_idx;
                h_last = out_last;
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        chk("unexpected_output", 32'(out_valid), 32'd0);
                    end else begin
                        e = q.pop_front();
                        chk("sum",  32'(out_sum),  32'(e.sum));
                        chk("idx",  32'(out_idx),  32'(e.idx));
                        chk("last", 32'(out_last), 32'(e.last));
                        chk("cout", 32'(out_cout), 32'(e.cout));
                        chk("ovf",  32'(out_ovf),  32'(e.ovf));
                        chk("err",  32'(out_err),  32'(e.err));
                    end
                end
            end
        end
    end

    task automatic drive_word(input logic [15:0] a, input logic [15:0] b,
                              input logic sub, input logic last);
        int t;
        t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        in_last  = last;
        #1;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Whole-operand reference: result = A +/- B over 16*n bits
    task automatic run_op(input int n, input logic [127:0] a_in, input logic [127:0] b_in,
                          input logic sub, input logic frc, input logic push);
        logic [127:0] a, b, res, mask, tmp;
        logic [128:0] full;
        logic         cout, ovf, sa, sb, sr;
        int           w;
        exp_t         e;
        w    = 16 * n;
        mask = (n == 8) ? '1 : ((128'd1 << w) - 128'd1);
        a    = a_in & mask;
        b    = b_in & mask;
        if (sub) begin
            res  = (a - b) & mask;
            cout = (a >= b);
        end else begin
            full = {1'b0, a} + {1'b0, b};
            tmp  = 128'(full >> w);
            cout = tmp[0];
            res  = 128'(full) & mask;
        end
        tmp = res >> (w - 1); sr = tmp[0];
        tmp = a >> (w - 1);   sa = tmp[0];
        tmp = b >> (w - 1);   sb = tmp[0];
        ovf = sub ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
        if (push) begin
            for (int i = 0; i < n; i++) begin
                tmp    = res >> (16 * i);
                e.sum  = tmp[15:0];
                e.last = (i == n - 1);
                e.cout = e.last ? cout : 1'b0;
                e.ovf  = e.last ? ovf : 1'b0;
                e.err  = e.last && frc;
                e.idx  = CW'(i);
                q.push_back(e);
            end
        end
        for (int i = 0; i < n; i++) begin
            logic [127:0] ta, tb;
            ta = a >> (16 * i);
            tb = b >> (16 * i);
            // in_sub on later words is deliberately inverted; it must be ignored
            drive_word(ta[15:0], tb[15:0], (i == 0) ? sub : ~sub, (i == n - 1) && !frc);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        bp_mode = 0;
        while ((q.size() != 0 || out_valid) && t < 500) begin
            @(negedge clk);
            t++;
        end
        repeat (2) @(negedge clk);
        chk("drain_queue_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n;
        logic frc;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum",   32'(out_sum),   32'd0);
        chk("rst_out_idx",   32'(out_idx),   32'd0);
        chk("rst_flags", 32'({out_last, out_cout, out_ovf, out_err}), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(2, 128'h0001_FFFF, 128'h0000_0001, 1'b0, 1'b0, 1'b1);
        run_op(1, 128'h0005, 128'h0007, 1'b1, 1'b0, 1'b1);
        run_op(1, 128'h0007, 128'h0005, 1'b1, 1'b0, 1'b1);
        run_op(1, 128'h7FFF, 128'h0001, 1'b0, 1'b0, 1'b1);
        run_op(1, 128'h8000, 128'h0001, 1'b1, 1'b0, 1'b1);
        drain();

        // Nine words without in_last: word 8 is forced last, word 9 starts fresh
        run_op(8, {$urandom(), $urandom(), $urandom(), $urandom()},
               {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0, 1'b1, 1'b1);
        run_op(1, 128'h1234, 128'h0234, 1'b1, 1'b0, 1'b1);
        drain();

        // Downstream stall during a 3-word add
        bp_mode = 2;
        fork
            run_op(3, 128'hFFFF_8000_FFFF, 128'h0001_8000_0001, 1'b0, 1'b0, 1'b1);
            begin
                repeat (2) @(negedge clk);
                #3;
                chk("stall_in_ready", 32'(in_ready), 32'd0);
                repeat (2) @(negedge clk);
                bp_mode = 0;
            end
        join
        drain();

        bp_mode = 1;
        for (int k = 0; k < 40; k++) begin
            n   = $urandom_range(1, MAXW);
            frc = (n == MAXW) && ($urandom_range(0, 1) == 1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op(n, {$urandom(), $urandom(), $urandom(), $urandom()},
                   {$urandom(), $urandom(), $urandom(), $urandom()},
                   1'($urandom_range(0, 1)), frc, 1'b1);
        end
        drain();

        // Reset mid-operation: first word of a 4-word add, then async reset
        bp_mode = 2;
        @(negedge clk);
        drive_word(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_sum",   32'(out_sum),   32'd0);
        chk("midrst_in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        bp_mode = 0;
        run_op(2, 128'h0003_0000, 128'h0004_0000, 1'b0, 1'b0, 1'b1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
